// File: rtl/ga23_pkg.sv
// Shared types and sizing helpers for the GA23 VRAM scheduler and layer mixer.
package ga23_pkg;

    // Width of the pen field at the bottom of a layer colour; pen 0 is transparent.
    localparam int PEN_W = 4;

    // CPU access states: waiting, queued for the CPU slot, data slot in flight.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACT  = 2'd2
    } cpu_st_t;

    // One address/data slot pair per layer plus one CPU pair.
    function automatic int sched_period(input int num_layers);
        return 2 * (num_layers + 1);
    endfunction

    function automatic int slot_width(input int num_layers);
        return $clog2(sched_period(num_layers));
    endfunction

endpackage

// File: rtl/ga23_layer_mix.sv
// Priority mixer: lowest-numbered enabled layer with a non-transparent pen wins;
// the last layer acts as an opaque backdrop when enabled. Registered on ce.
module ga23_layer_mix
    import ga23_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int COLOR_W    = 11,
    parameter int PRIO_W     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ce,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0]  layer_color,
    input  logic [NUM_LAYERS*PRIO_W-1:0]   layer_prio,
    output logic [COLOR_W-1:0]             color_out,
    output logic [PRIO_W-1:0]              prio_out
);

    logic [COLOR_W-1:0] color_d, color_q;
    logic [PRIO_W-1:0]  prio_d, prio_q;

    // Pick the winning layer; the descending loop lets the lowest index override.
    always_comb begin
        color_d = color_q;
        prio_d  = prio_q;
        if (ce) begin
            color_d = '0;
            prio_d  = '0;
            if (layer_en[NUM_LAYERS-1]) begin
                color_d = layer_color[(NUM_LAYERS-1)*COLOR_W +: COLOR_W];
                prio_d  = layer_prio[(NUM_LAYERS-1)*PRIO_W +: PRIO_W];
            end
            for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
                if (layer_en[k] && (layer_color[k*COLOR_W +: PEN_W] != '0)) begin
                    color_d = layer_color[k*COLOR_W +: COLOR_W];
                    prio_d  = layer_prio[k*PRIO_W +: PRIO_W];
                end
            end
        end
    end

    // Output register gives the mixer its one-ce latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_q <= '0;
            prio_q  <= '0;
        end else begin
            color_q <= color_d;
            prio_q  <= prio_d;
        end
    end

    assign color_out = color_q;
    assign prio_out  = prio_q;

endmodule

// File: rtl/ga23_vram_sched.sv
// VRAM time-slot scheduler: layer fetch slot pairs followed by one CPU slot pair
// per period, with CPU request queueing, overrun detection and the layer mixer.
module ga23_vram_sched
    import ga23_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int COLOR_W    = 11,
    parameter int PRIO_W     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ce,
    input  logic                           cpu_req,
    input  logic                           cpu_we,
    input  logic [ADDR_W-1:0]              cpu_addr,
    input  logic [DATA_W-1:0]              cpu_din,
    output logic [DATA_W-1:0]              cpu_dout,
    output logic                           busy,
    output logic                           overrun,
    input  logic [NUM_LAYERS*ADDR_W-1:0]   layer_vram_addr,
    output logic [NUM_LAYERS-1:0]          layer_load,
    output logic [DATA_W-1:0]              index_latch,
    output logic [ADDR_W-1:0]              vram_addr,
    input  logic [DATA_W-1:0]              vram_din,
    output logic [DATA_W-1:0]              vram_dout,
    output logic                           vram_we,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0]  layer_color,
    input  logic [NUM_LAYERS*PRIO_W-1:0]   layer_prio,
    output logic [COLOR_W-1:0]             color_out,
    output logic [PRIO_W-1:0]              prio_out,
    output logic                           period_start
);

    localparam int P      = sched_period(NUM_LAYERS);
    localparam int SLOT_W = slot_width(NUM_LAYERS);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(P - 1);
    localparam logic [SLOT_W-1:0] SLOT_CPU_A = SLOT_W'(2 * NUM_LAYERS);
    localparam logic [SLOT_W-1:0] SLOT_CPU_D = SLOT_W'(2 * NUM_LAYERS + 1);

    cpu_st_t                 st_d, st_q;
    logic [SLOT_W-1:0]       slot_d, slot_q;
    logic [ADDR_W-1:0]       vram_addr_d, vram_addr_q;
    logic [DATA_W-1:0]       vram_dout_d, vram_dout_q;
    logic                    vram_we_d, vram_we_q;
    logic [NUM_LAYERS-1:0]   layer_load_d, layer_load_q;
    logic [DATA_W-1:0]       index_latch_d, index_latch_q;
    logic [DATA_W-1:0]       cpu_dout_d, cpu_dout_q;
    logic                    busy_d, busy_q;
    logic                    overrun_d, overrun_q;
    logic                    period_start_d, period_start_q;
    logic [ADDR_W-1:0]       req_addr_d, req_addr_q;
    logic [DATA_W-1:0]       req_din_d, req_din_q;
    logic                    req_we_d, req_we_q;

    // Slot sequencing, layer fetches and the CPU access state machine.
    always_comb begin
        st_d           = st_q;
        slot_d         = slot_q;
        vram_addr_d    = vram_addr_q;
        vram_dout_d    = vram_dout_q;
        vram_we_d      = 1'b0;
        layer_load_d   = ce ? '0 : layer_load_q;
        index_latch_d  = index_latch_q;
        cpu_dout_d     = cpu_dout_q;
        overrun_d      = overrun_q;
        period_start_d = period_start_q;
        req_addr_d     = req_addr_q;
        req_din_d      = req_din_q;
        req_we_d       = req_we_q;

        if (ce) begin
            slot_d         = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            period_start_d = (slot_d == '0);
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (slot_q == SLOT_W'(2 * k)) begin
                    vram_addr_d = layer_vram_addr[k*ADDR_W +: ADDR_W];
                end
                if (slot_q == SLOT_W'(2 * k + 1)) begin
                    vram_addr_d[0]  = 1'b1;
                    index_latch_d   = vram_din;
                    layer_load_d[k] = 1'b1;
                end
            end
        end

        case (st_q)
            IDLE: begin
                if (cpu_req) begin
                    st_d       = PEND;
                    req_addr_d = cpu_addr;
                    req_din_d  = cpu_din;
                    req_we_d   = cpu_we;
                end
            end
            PEND: begin
                if (cpu_req) begin
                    overrun_d = 1'b1;
                end
                if (ce && (slot_q == SLOT_CPU_A)) begin
                    vram_addr_d = req_addr_q;
                    vram_dout_d = req_din_q;
                    vram_we_d   = req_we_q;
                    st_d        = ACT;
                end
            end
            ACT: begin
                if (ce && (slot_q == SLOT_CPU_D)) begin
                    cpu_dout_d = vram_din;
                    st_d       = IDLE;
                    if (cpu_req) begin
                        st_d       = PEND;
                        req_addr_d = cpu_addr;
                        req_din_d  = cpu_din;
                        req_we_d   = cpu_we;
                    end
                end else if (cpu_req) begin
                    overrun_d = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase

        busy_d = (st_d != IDLE);
    end

    // State and registered outputs; reset abandons any queued access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q           <= IDLE;
            slot_q         <= '0;
            vram_addr_q    <= '0;
            vram_dout_q    <= '0;
            vram_we_q      <= 1'b0;
            layer_load_q   <= '0;
            index_latch_q  <= '0;
            cpu_dout_q     <= '0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            period_start_q <= 1'b0;
            req_addr_q     <= '0;
            req_din_q      <= '0;
            req_we_q       <= 1'b0;
        end else begin
            st_q           <= st_d;
            slot_q         <= slot_d;
            vram_addr_q    <= vram_addr_d;
            vram_dout_q    <= vram_dout_d;
            vram_we_q      <= vram_we_d;
            layer_load_q   <= layer_load_d;
            index_latch_q  <= index_latch_d;
            cpu_dout_q     <= cpu_dout_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            period_start_q <= period_start_d;
            req_addr_q     <= req_addr_d;
            req_din_q      <= req_din_d;
            req_we_q       <= req_we_d;
        end
    end

    assign vram_addr    = vram_addr_q;
    assign vram_dout    = vram_dout_q;
    assign vram_we      = vram_we_q;
    assign layer_load   = layer_load_q;
    assign index_latch  = index_latch_q;
    assign cpu_dout     = cpu_dout_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign period_start = period_start_q;

    ga23_layer_mix #(
        .NUM_LAYERS (NUM_LAYERS),
        .COLOR_W    (COLOR_W),
        .PRIO_W     (PRIO_W)
    ) u_mix (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .layer_en    (layer_en),
        .layer_color (layer_color),
        .layer_prio  (layer_prio),
        .color_out   (color_out),
        .prio_out    (prio_out)
    );

endmodule

// File: tb/tb_ga23_vram_sched.sv
// Directed bench for ga23_vram_sched with NUM_LAYERS=3 (period 8) and ce held high.
module tb_ga23_vram_sched;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [14:0]   cpu_addr = '0;
    logic [15:0]   cpu_din = '0;
    logic [15:0]   cpu_dout;
    logic          busy;
    logic          overrun;
    logic [44:0]   layer_vram_addr = {15'h4400, 15'h2200, 15'h0100};
    logic [2:0]    layer_load;
    logic [15:0]   index_latch;
    logic [14:0]   vram_addr;
    logic [15:0]   vram_din;
    logic [15:0]   vram_dout;
    logic          vram_we;
    logic [2:0]    layer_en = '0;
    logic [32:0]   layer_color = '0;
    logic [5:0]    layer_prio = '0;
    logic [10:0]   color_out;
    logic [1:0]    prio_out;
    logic          period_start;

    int n_checks = 0;
    int n_fail = 0;
    int we_count = 0;

    logic          wr_valid = 1'b0;
    logic [14:0]   wr_addr = '0;
    logic [15:0]   wr_data = '0;

    ga23_vram_sched dut (
        .clk             (clk),
        .reset           (reset),
        .ce              (ce),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_din         (cpu_din),
        .cpu_dout        (cpu_dout),
        .busy            (busy),
        .overrun         (overrun),
        .layer_vram_addr (layer_vram_addr),
        .layer_load      (layer_load),
        .index_latch     (index_latch),
        .vram_addr       (vram_addr),
        .vram_din        (vram_din),
        .vram_dout       (vram_dout),
        .vram_we         (vram_we),
        .layer_en        (layer_en),
        .layer_color     (layer_color),
        .layer_prio      (layer_prio),
        .color_out       (color_out),
        .prio_out        (prio_out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    // VRAM stand-in: unwritten words read as addr ^ 0x5A18, so 0x0042 holds 0x5A5A.
    assign vram_din = (wr_valid && (vram_addr == wr_addr)) ? wr_data
                                                           : ({1'b0, vram_addr} ^ 16'h5A18);

    // Record the last write and count every write strobe seen.
    always @(posedge clk) begin
        if (vram_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= vram_addr;
            wr_data  <= vram_dout;
            we_count <= we_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic we,
                                 input logic [14:0] addr, input logic [15:0] din);
        cpu_req  = req;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Linear directed sequence; bench slot position is tracked by counting ticks.
    initial begin
        logic [14:0] ea;
        logic [2:0]  el;
        logic [15:0] ei;
        int          s;

        #1;
        checkOutput("rst vram_addr", vram_addr, 0);
        checkOutput("rst layer_load", layer_load, 0);
        checkOutput("rst index_latch", index_latch, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst overrun", overrun, 0);
        checkOutput("rst period_start", period_start, 0);
        checkOutput("rst color_out", color_out, 0);
        checkOutput("rst prio_out", prio_out, 0);
        checkOutput("rst vram_we", vram_we, 0);
        checkOutput("rst vram_dout", vram_dout, 0);
        checkOutput("rst cpu_dout", cpu_dout, 0);
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] free-running slot schedule");
        for (int n = 1; n <= 16; n++) begin
            tick();
            s = (n - 1) % 8;
            case (s)
                0: ea = 15'h0100;
                1: ea = 15'h0101;
                2: ea = 15'h2200;
                3: ea = 15'h2201;
                4: ea = 15'h4400;
                default: ea = 15'h4401;
            endcase
            el = (s == 1) ? 3'b001 : (s == 3) ? 3'b010 : (s == 5) ? 3'b100 : 3'b000;
            if (s == 1 || s == 2)      ei = 16'h5B18;
            else if (s == 3 || s == 4) ei = 16'h7818;
            else if (s >= 5)           ei = 16'h1E18;
            else                       ei = (n == 1) ? 16'h0000 : 16'h1E18;
            checkOutput($sformatf("run vram_addr slot%0d n%0d", s, n), vram_addr, ea);
            checkOutput($sformatf("run layer_load slot%0d n%0d", s, n), layer_load, el);
            checkOutput($sformatf("run index_latch slot%0d n%0d", s, n), index_latch, ei);
            checkOutput($sformatf("run period_start slot%0d n%0d", s, n), period_start, (s == 7));
            checkOutput($sformatf("run vram_we slot%0d n%0d", s, n), vram_we, 0);
        end

        $display("[TB] ce low holds everything");
        ce = 1'b0;
        tick();
        tick();
        checkOutput("celow period_start", period_start, 1);
        checkOutput("celow vram_addr", vram_addr, 15'h4401);
        checkOutput("celow layer_load", layer_load, 0);
        ce = 1'b1;

        $display("[TB] CPU write requested at slot 2");
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 15'h1234, 16'hBEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0);
        checkOutput("wr busy rise", busy, 1);
        for (int i = 3; i <= 5; i++) begin
            tick();
            checkOutput($sformatf("wr vram_we slot%0d", i), vram_we, 0);
        end
        tick();
        checkOutput("wr vram_we slot6", vram_we, 1);
        checkOutput("wr vram_addr slot6", vram_addr, 15'h1234);
        checkOutput("wr vram_dout slot6", vram_dout, 16'hBEEF);
        checkOutput("wr busy slot6", busy, 1);
        tick();
        checkOutput("wr vram_we slot7", vram_we, 0);
        checkOutput("wr busy fall", busy, 0);
        checkOutput("wr strobe count", we_count, 1);

        $display("[TB] CPU read requested at slot 7");
        for (int i = 0; i < 7; i++) tick();
        applyStimulus(1'b1, 1'b0, 15'h0042, 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0);
        checkOutput("rd busy rise", busy, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("rd busy slot%0d", i), busy, (i < 7));
            checkOutput($sformatf("rd vram_we slot%0d", i), vram_we, 0);
        end
        checkOutput("rd cpu_dout", cpu_dout, 16'h5A5A);
        checkOutput("rd overrun", overrun, 0);

        $display("[TB] overrun and back-to-back requests");
        applyStimulus(1'b1, 1'b0, 15'h0010, 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0);
        tick();
        tick();
        checkOutput("ovr before", overrun, 0);
        applyStimulus(1'b1, 1'b1, 15'h0777, 16'hDEAD);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0);
        checkOutput("ovr set", overrun, 1);
        checkOutput("ovr busy", busy, 1);
        tick();
        tick();
        tick();
        checkOutput("ovr vram_addr slot6", vram_addr, 15'h0010);
        checkOutput("ovr vram_we slot6", vram_we, 0);
        applyStimulus(1'b1, 1'b0, 15'h0042, 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0);
        checkOutput("b2b busy held", busy, 1);
        checkOutput("b2b first cpu_dout", cpu_dout, 16'h5A08);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("b2b busy slot%0d", i), busy, (i < 7));
            if (i == 6) checkOutput("b2b vram_addr slot6", vram_addr, 15'h0042);
        end
        checkOutput("b2b second cpu_dout", cpu_dout, 16'h5A5A);
        checkOutput("b2b strobe count", we_count, 1);

        $display("[TB] layer mixer");
        layer_color = {11'h3A7, 11'h125, 11'h010};
        layer_prio  = {2'd3, 2'd2, 2'd1};
        layer_en    = 3'b111;
        #1;
        checkOutput("mix latency", color_out, 0);
        tick();
        checkOutput("mix en111 color", color_out, 11'h125);
        checkOutput("mix en111 prio", prio_out, 2);
        layer_en = 3'b101;
        #1;
        checkOutput("mix hold before ce", color_out, 11'h125);
        tick();
        checkOutput("mix en101 color", color_out, 11'h3A7);
        checkOutput("mix en101 prio", prio_out, 3);
        layer_color = {11'h300, 11'h120, 11'h010};
        layer_en    = 3'b011;
        tick();
        checkOutput("mix pen0 color", color_out, 0);
        checkOutput("mix pen0 prio", prio_out, 0);
        layer_en = 3'b100;
        tick();
        checkOutput("mix backdrop color", color_out, 11'h300);
        checkOutput("mix backdrop prio", prio_out, 3);

        $display("[TB] reset during a pending write");
        applyStimulus(1'b1, 1'b1, 15'h0555, 16'h1111);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 16'h0);
        checkOutput("rstp busy before", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstp busy", busy, 0);
        checkOutput("rstp vram_addr", vram_addr, 0);
        checkOutput("rstp vram_we", vram_we, 0);
        checkOutput("rstp vram_dout", vram_dout, 0);
        checkOutput("rstp overrun", overrun, 0);
        checkOutput("rstp cpu_dout", cpu_dout, 0);
        checkOutput("rstp index_latch", index_latch, 0);
        checkOutput("rstp color_out", color_out, 0);
        checkOutput("rstp period_start", period_start, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rstp slot0 vram_addr", vram_addr, 15'h0100);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("rstp no write", we_count, 1);
        checkOutput("rstp busy after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ga23_vram_sched.md
Name: ga23_vram_sched

Overview:
- Parametrised VRAM time-slot scheduler and layer mixer for the GA23-family tilemap chip.
- Generalises the fixed 3-layer, 8-slot loop to NUM_LAYERS layers. Each layer gets an address/data slot pair per period; one CPU slot pair closes each period.
- Adds per-layer enable, a CPU request-overrun flag and a period-start strobe.
- Sits between the layer engines (ga23_layer instances), the VRAM, the CPU bus decode and the palette stage.

Parameters:
- NUM_LAYERS, 3, number of tilemap layers (1..6)
- ADDR_W, 15, VRAM word-address width
- DATA_W, 16, VRAM data width
- COLOR_W, 11, layer colour width; bits [3:0] are the pen
- PRIO_W, 2, layer priority width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ce  in  1  pixel clock enable; all slot/mixer activity advances only on ce
- cpu_req  in  1  one-clk access request pulse
- cpu_we  in  1  write qualifier, sampled with cpu_req
- cpu_addr  in  ADDR_W  word address, sampled with cpu_req
- cpu_din  in  DATA_W  write data, sampled with cpu_req
- cpu_dout  out  DATA_W  read data, valid when busy falls
- busy  out  1  CPU access outstanding
- overrun  out  1  sticky: cpu_req arrived while busy; cleared by reset only
- layer_vram_addr  in  NUM_LAYERS*ADDR_W  per-layer fetch address, layer k at [k*ADDR_W +: ADDR_W]
- layer_load  out  NUM_LAYERS  one-ce strobe: index/attrib pair valid for layer k
- index_latch  out  DATA_W  first (index) word of the current fetch
- vram_addr  out  ADDR_W  VRAM address
- vram_din  in  DATA_W  VRAM read data, 1-ce latency
- vram_dout  out  DATA_W  VRAM write data
- vram_we  out  1  VRAM write strobe
- layer_en  in  NUM_LAYERS  per-layer mixer enable
- layer_color  in  NUM_LAYERS*COLOR_W  per-layer pixel colour
- layer_prio  in  NUM_LAYERS*PRIO_W  per-layer pixel priority
- color_out  out  COLOR_W  mixed colour
- prio_out  out  PRIO_W  mixed priority
- period_start  out  1  high during the ce where slot==0

Behaviour:
- Reset values: all outputs 0; slot=0; CPU FSM IDLE.
- Period P = 2*(NUM_LAYERS+1) slots; slot counter width clog2(P). Slot increments per ce and wraps P-1 -> 0.
- Slot 2k (k<NUM_LAYERS): vram_addr <= layer_vram_addr[k].
- Slot 2k+1: vram_addr[0] <= 1; index_latch <= vram_din; layer_load[k] <= 1 for that ce. The layer reads attrib from vram_din on the next ce.
- layer_load bits clear on every other ce. Exactly one bit is set at a time.
- CPU FSM states: IDLE, PEND, ACT.
  - IDLE + cpu_req -> PEND. Addr, data and we are latched; busy=1 from the next clk.
  - PEND at slot 2N: vram_addr <= cpu addr; vram_dout <= data; vram_we=1 for one clk only if we; -> ACT.
  - ACT at slot 2N+1: cpu_dout <= vram_din (also on writes: read-back value); -> IDLE; busy=0.
  - Worst-case latency from request to busy low: P+2 ce.
- cpu_req while PEND/ACT: ignored, overrun<=1. Exception: cpu_req in the clk where ACT->IDLE is accepted (-> PEND, busy stays 1).
- Request arriving at slot 2N exactly: it becomes PEND only after that ce, so it is serviced next period.
- Slot 2N with no pending request: vram_addr is held; no write.
- Mixer, registered on ce, 1-ce latency:
  - Lowest index k with layer_en[k] and layer_color[k][3:0]!=0 wins.
  - Otherwise, if layer_en[N-1], output layer N-1 colour/prio as-is (backdrop).
  - Otherwise output 0/0.
- Reset mid-access: FSM -> IDLE, busy=0, pending write discarded, vram_we=0.
- ce low: nothing advances except CPU request capture and the overrun flag.

Decomposition:
- Package ga23_pkg:
  - cpu_st_t enum (IDLE, PEND, ACT)
  - localparam function for P and slot width
  - PEN_W=4 constant
- Natural sub-module: ga23_layer_mix (parametrised priority mixer, combinational pick plus ce register). The scheduler FSM stays in ga23_vram_sched.

Test Plan (NUM_LAYERS=3, P=8, ce every clk):
- Free-run with layer_vram_addr = 0x0100/0x2200/0x4400 -> vram_addr shows 0x0100, 0x0101, 0x2200, 0x2201, 0x4400, 0x4401 at slots 0..5; layer_load = 001, 010, 100 at slots 1, 3, 5; period_start every 8 ce.
- Write cpu_req at slot 2, addr 0x1234, data 0xBEEF -> vram_addr=0x1234, vram_we one clk at slot 6; busy falls after slot 7; no other vram_we pulses.
- Read at slot 7 with VRAM holding 0x5A5A at 0x0042 -> serviced next period; cpu_dout=0x5A5A; busy high 8 ce (slot 7 -> next slot 7); overrun=0.
- Second cpu_req while busy -> overrun=1 and the access is not performed; request in the ACT->IDLE clk -> accepted, busy continuous, no overrun.
- Mixer: colours 0x010/0x125/0x3A7, layer_en=111 -> 0x125 one ce later; layer_en=101 -> 0x3A7; colours all pen 0, layer_en=011 -> 0x000 / prio 0.
- Assert reset while PEND with cpu_we=1 -> no vram_we ever; busy=0, slot=0, all outputs 0 immediately.
